delay_line_var: RTL

DELAY_LINE_VAR -- requirements
Module: delay_line_var

---
 rtl/delay_pkg.sv | 20 ++
 rtl/delay_tap_mux.sv | 29 ++
 rtl/delay_line_var.sv | 91 +++++++++
 3 files changed

// File: rtl/delay_pkg.sv
`default_nettype none
// ============================================================================
// Module      : delay_pkg
// Description : Width helpers shared by the variable delay line and its tap mux.
// Revision    : 1.0 - initial release
// ============================================================================
package delay_pkg;

    // Width of the delay select: must encode 0..max_delay inclusive.
    function automatic int dly_width(input int max_delay);
        return $clog2(max_delay + 1);
    endfunction

    // One line stage packs {vld, data[width-1:0]}; vld is the MSB.
    function automatic int stage_width(input int width);
        return width + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/delay_tap_mux.sv
`default_nettype none
// ============================================================================
// Module      : delay_tap_mux
// Description : Selects stage[sel-1] from the line; sel=0 yields all zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module delay_tap_mux
    import delay_pkg::*;
#(
    parameter int  SW        = 9,
    parameter int  MAX_DELAY = 16,
    localparam int DW        = dly_width(MAX_DELAY)
) (
    input  logic [MAX_DELAY-1:0][SW-1:0] stages,
    input  logic [DW-1:0]                sel,
    output logic [SW-1:0]                tap
);

    always_comb begin
        tap = '0;
        for (int i = 0; i < MAX_DELAY; i++) begin
            if (sel == DW'(i + 1)) begin
                tap = stages[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/delay_line_var.sv
`default_nettype none
// ============================================================================
// Module      : delay_line_var
// Description : Register-based delay line with run-time selectable depth,
//               clock enable, flush and fill tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module delay_line_var
    import delay_pkg::*;
#(
    parameter int  WIDTH     = 8,
    parameter int  MAX_DELAY = 16,
    localparam int DW        = dly_width(MAX_DELAY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             flush,
    input  logic [DW-1:0]    dly_sel,
    input  logic             din_vld,
    input  logic [WIDTH-1:0] din,
    output logic             dout_vld,
    output logic [WIDTH-1:0] dout,
    output logic             primed,
    output logic             dly_err
);

    localparam int          SW    = stage_width(WIDTH);
    localparam logic [DW-1:0] C_MAX = DW'(MAX_DELAY);

    logic [MAX_DELAY-1:0][SW-1:0] r_stage;
    logic [DW-1:0]                r_dly_cur;
    logic [DW-1:0]                r_fill_cnt;
    logic                         r_dly_err;
    logic [SW-1:0]                w_tap;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dly_cur <= '0;
            r_dly_err <= 1'b0;
        end else begin
            r_dly_cur <= (dly_sel > C_MAX) ? C_MAX : dly_sel;
            r_dly_err <= (dly_sel > C_MAX);
        end
    end

    // Fill count only ever needs to reach MAX_DELAY, the deepest tap.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_fill_cnt <= '0;
        end else if (ce && (r_fill_cnt != C_MAX)) begin
            r_fill_cnt <= r_fill_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_stage <= '0;
        end else if (ce) begin
            r_stage[0] <= {din_vld, din};
            for (int i = 1; i < MAX_DELAY; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    delay_tap_mux #(
        .SW        (SW),
        .MAX_DELAY (MAX_DELAY)
    ) u_tap_mux (
        .stages (r_stage),
        .sel    (r_dly_cur),
        .tap    (w_tap)
    );

    assign primed  = (r_fill_cnt >= r_dly_cur);
    assign dly_err = r_dly_err;

    // Zero delay is a pure bypass of the current input.
    always_comb begin
        if (r_dly_cur == '0) begin
            dout     = din;
            dout_vld = din_vld;
        end else begin
            dout     = w_tap[WIDTH-1:0];
            dout_vld = w_tap[SW-1] & primed;
        end
    end

endmodule
`default_nettype wire
